// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo
//   Keystroke receive FIFO with a two-register CPU read port.
//   Keystrokes arrive as one-cycle strobes and are queued in a circular
//   buffer. The CPU reads either the oldest queued character (address 0)
//   or a status byte (address 1). An access is triggered by the rising
//   edge of cs.
//
// Ports
//   usb_clk   : sole clock, all state updates on the rising edge
//   rst       : synchronous, active-high reset
//   key_valid : one-cycle strobe, key_char holds a new keystroke
//   key_char  : 7-bit ASCII keystroke
//   cs        : CPU chip select, active high
//   address   : 0 = RX data register, 1 = RX status register
//   dout      : registered read data
//                 data   = {1, char}
//                 status = {not empty, overflow, 6'b0}
//   count     : current occupancy, 0..DEPTH
//   overflow  : sticky flag, set when a keystroke is dropped
module kbd_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     usb_clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [6:0]               key_char,
  input  logic                     cs,
  input  logic                     address,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [6:0]    last_char;
  logic          cs_q;
  logic          cs_armed;

  logic empty;
  logic full;
  logic start;
  logic rd_data;
  logic rd_stat;
  logic pop;
  logic push;
  logic drop;

  // A cs held high through reset must not count as a rising edge.
  // cs_armed records that cs has been seen low since the reset.
  assign start   = cs & ~cs_q & cs_armed;
  assign rd_data = start & ~address;
  assign rd_stat = start & address;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign pop  = rd_data & ~empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the key.
  assign push = key_valid & (~full | pop);
  assign drop = key_valid & full & ~pop;

  // Storage is not reset.
  always_ff @(posedge usb_clk) begin
    if (!rst && push) begin
      mem[wptr] <= key_char;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (rst) begin
      dout      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      last_char <= '0;
      cs_q      <= 1'b0;
      cs_armed  <= ~cs;
    end else begin
      cs_q     <= cs;
      cs_armed <= cs_armed | ~cs;

      if (push) begin
        wptr <= wptr + AW'(1);
      end

      if (rd_data) begin
        if (pop) begin
          // Reads the pre-edge entry; a same-cycle push never bypasses.
          dout      <= {1'b1, mem[rptr]};
          last_char <= mem[rptr];
          rptr      <= rptr + AW'(1);
        end else begin
          dout <= {1'b1, last_char};
        end
      end else if (rd_stat) begin
        dout <= {~empty, overflow, 6'b0};
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Set wins over the clear from a same-cycle status read.
      if (drop) begin
        overflow <= 1'b1;
      end else if (rd_stat) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// tb_kbd_rx_fifo
//   Directed bench for kbd_rx_fifo (DEPTH=8). A queue-based model of the
//   FIFO produces the expected read data, which is pushed onto a
//   scoreboard when an access is driven and popped when dout is checked.
module tb_kbd_rx_fifo;

  localparam int DEPTH = 8;

  logic       usb_clk;
  logic       rst;
  logic       key_valid;
  logic [6:0] key_char;
  logic       cs;
  logic       address;
  logic [7:0] dout;
  logic [3:0] count;
  logic       overflow;

  kbd_rx_fifo #(.DEPTH(DEPTH)) dut (
    .usb_clk   (usb_clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_char  (key_char),
    .cs        (cs),
    .address   (address),
    .dout      (dout),
    .count     (count),
    .overflow  (overflow)
  );

  initial usb_clk = 1'b0;
  always #5 usb_clk = ~usb_clk;

  // Reference model state
  logic [6:0] mq [$];
  logic [7:0] exp_q [$];
  logic [6:0] mlast;
  logic       movf;
  logic [7:0] last_dout;

  int tests;
  int fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One directed cycle: optional keystroke and optional access start.
  // An access is followed by one idle cycle so the next access sees cs low.
  task automatic step(input string tag, input logic kv, input logic [6:0] kc,
                      input logic acc, input logic addr);
    logic [7:0] e;
    int         pre_n;
    logic       pre_ovf;
    bit         popped;
    pre_n   = mq.size();
    pre_ovf = movf;
    popped  = 0;
    e       = '0;
    if (acc) begin
      if (!addr) begin
        if (pre_n > 0) begin
          mlast  = mq.pop_front();
          popped = 1;
        end
        e = {1'b1, mlast};
      end else begin
        e    = {(pre_n != 0), pre_ovf, 6'b0};
        movf = 1'b0;
      end
      exp_q.push_back(e);
    end
    if (kv) begin
      if (pre_n < DEPTH || popped) mq.push_back(kc);
      else movf = 1'b1;
    end
    key_valid = kv;
    key_char  = kc;
    cs        = acc;
    address   = addr;
    @(posedge usb_clk);
    #1;
    key_valid = 1'b0;
    cs        = 1'b0;
    chk({tag, "_count"}, 32'(count), 32'(mq.size()));
    chk({tag, "_ovf"}, 32'(overflow), 32'(movf));
    chk({tag, "_cnt_le_depth"}, 32'(count <= 4'(DEPTH)), 32'd1);
    if (acc) begin
      e = exp_q.pop_front();
      chk({tag, "_dout"}, 32'(dout), 32'(e));
      last_dout = e;
      @(posedge usb_clk);
      #1;
      chk({tag, "_dout_hold"}, 32'(dout), 32'(last_dout));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] e;
    tests     = 0;
    fails     = 0;
    mlast     = '0;
    movf      = 1'b0;
    last_dout = '0;
    rst       = 1'b1;
    key_valid = 1'b0;
    key_char  = '0;
    cs        = 1'b0;
    address   = 1'b0;

    // Reset state
    repeat (2) @(posedge usb_clk);
    #1;
    rst = 1'b0;
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // Single key then read, then read while empty returns last_char
    step("push_A", 1'b1, 7'h41, 1'b0, 1'b0);
    step("read_A", 1'b0, 7'h00, 1'b1, 1'b0);
    step("read_empty", 1'b0, 7'h00, 1'b1, 1'b0);

    // Overfill: 9 keys into 8 entries
    for (int unsigned i = 0; i < 9; i++)
      step("fill9", 1'b1, 7'(8'h30 + i), 1'b0, 1'b0);
    // Status read coincident with a drop: old flag shown, flag stays set
    step("stat_drop", 1'b1, 7'h39, 1'b1, 1'b1);
    step("stat_c0", 1'b0, 7'h00, 1'b1, 1'b1);
    step("stat_80", 1'b0, 7'h00, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 8; i++)
      step("drain9", 1'b0, 7'h00, 1'b1, 1'b0);

    // Full FIFO: push with simultaneous pop, no drop
    for (int unsigned i = 0; i < 8; i++)
      step("fill8", 1'b1, 7'(8'h40 + i), 1'b0, 1'b0);
    step("full_push_pop", 1'b1, 7'h5A, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 8; i++)
      step("drain_5a", 1'b0, 7'h00, 1'b1, 1'b0);

    // Empty FIFO: push with simultaneous read
    step("empty_push_read", 1'b1, 7'h55, 1'b1, 1'b0);
    step("read_55", 1'b0, 7'h00, 1'b1, 1'b0);

    // Holding cs high yields exactly one pop
    step("q3", 1'b1, 7'h61, 1'b0, 1'b0);
    step("q3", 1'b1, 7'h62, 1'b0, 1'b0);
    step("q3", 1'b1, 7'h63, 1'b0, 1'b0);
    mlast = mq.pop_front();
    exp_q.push_back({1'b1, mlast});
    cs      = 1'b1;
    address = 1'b0;
    @(posedge usb_clk);
    #1;
    e = exp_q.pop_front();
    for (int unsigned i = 0; i < 5; i++) begin
      chk("hold_cs_dout", 32'(dout), 32'(e));
      chk("hold_cs_count", 32'(count), 32'd2);
      if (i < 4) begin
        @(posedge usb_clk);
        #1;
      end
    end
    cs = 1'b0;
    @(posedge usb_clk);
    #1;

    // Interleaved traffic across pointer wrap-around
    for (int unsigned i = 0; i < 12; i++)
      step("interleave", 1'b1, 7'(8'h10 + i), 1'((i % 2) == 1), 1'b0);
    while (mq.size() > 0)
      step("interleave_drain", 1'b0, 7'h00, 1'b1, 1'b0);

    // Reset with 4 entries, overflow set, key strobed and cs high
    for (int unsigned i = 0; i < 9; i++)
      step("pre_rst_fill", 1'b1, 7'(8'h20 + i), 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++)
      step("pre_rst_read", 1'b0, 7'h00, 1'b1, 1'b0);
    rst       = 1'b1;
    key_valid = 1'b1;
    key_char  = 7'h7F;
    cs        = 1'b1;
    address   = 1'b0;
    @(posedge usb_clk);
    #1;
    rst       = 1'b0;
    key_valid = 1'b0;
    mq.delete();
    mlast = '0;
    movf  = 1'b0;
    chk("mid_rst_dout", 32'(dout), 32'h00);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    // cs still high from reset: no access until it drops and rises again
    repeat (2) begin
      @(posedge usb_clk);
      #1;
      chk("no_start_after_rst", 32'(dout), 32'h00);
    end
    cs = 1'b0;
    @(posedge usb_clk);
    #1;
    step("post_rst_read", 1'b0, 7'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kbd_rx_fifo.md
KBD_RX_FIFO -- requirements
Module: kbd_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entry count; power of two, 2..64.
REQ-002 Port: usb_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: key_valid  input  1  one-cycle strobe; key_char is a new keystroke.
REQ-005 Port: key_char  input  7  7-bit ASCII of the keystroke, sampled when key_valid=1.
REQ-006 Port: cs  input  1  CPU chip select, active high.
REQ-007 Port: address  input  1  0 = RX data register, 1 = RX status register.
REQ-008 Port: dout  output  8  registered CPU read data.
REQ-009 Port: count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 Port: overflow  output  1  sticky flag: a keystroke was dropped.

Function
REQ-011 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-012 empty = (count==0), full = (count==DEPTH); both SHALL be derived from count, not from the pointers.
REQ-013 An access SHALL start on the first cycle cs=1 after a cycle with cs=0 (registered cs_q); holding cs high SHALL NOT cause further accesses.
REQ-014 Push: key_valid=1 and not full SHALL write key_char at wptr, advance wptr, and raise count by 1 at the next edge.
REQ-015 Drop: key_valid=1, full, and no pop in the same cycle SHALL discard key_char, set overflow=1, and leave pointers and count unchanged.
REQ-016 Data read: an access start with address=0 and not empty SHALL load dout <= {1, mem[rptr]} at the next edge, advance rptr, lower count by 1, and store the char in last_char.
REQ-017 Data read when empty SHALL load dout <= {1, last_char}, with no pointer or count change.
REQ-018 Status read: an access start with address=1 SHALL load dout <= {~empty, overflow, 6'b0} from pre-edge values and clear overflow.
REQ-019 Status read and drop in the same cycle: dout bit6 shows the old overflow value; overflow ends at 1 (set wins).
REQ-020 Push and pop in the same cycle SHALL both take effect with count unchanged, including when full (no drop, no overflow).
REQ-021 Push when empty plus data read in the same cycle: the read follows REQ-017 and the push enqueues; count ends at 1.
REQ-022 Pop reads mem[rptr] before any same-cycle write; no bypass of the pushed char to dout.
REQ-023 dout SHALL hold its value in every cycle without an access start.
REQ-024 Read latency: dout valid one edge after the access-start cycle.

Reset
REQ-025 While rst=1 at an edge: dout=8'h00, count=0, overflow=0, wptr=rptr=0, last_char=7'h00, cs_q=0; memory contents need not be cleared.
REQ-026 Reset SHALL override any same-cycle push, pop, or status read; a keystroke strobed during reset is lost and does not set overflow.
REQ-027 After reset deassertion, cs already high SHALL NOT start an access until cs goes low and then high again.

Verification
REQ-028 Push 'A' (7'h41), then a data read: dout=8'hC1 one cycle later; count goes 1->0; a second read returns 8'hC1 (empty, last_char).
REQ-029 DEPTH=8: push 0x30..0x38 (9 keys): count=8, overflow=1; status read -> dout=8'hC0 and overflow cleared; a second status read -> 8'h80.
REQ-030 Fill to full, then push 0x5A together with a data read: no overflow, count stays 8; the ninth read returns 8'hDA.
REQ-031 Hold cs=1, address=0 for 5 cycles with 3 entries queued: exactly one pop, count=2, dout constant.
REQ-032 Push 12 and pop 12 interleaved across wrap-around: output order matches input order; count never exceeds 8.
REQ-033 Assert rst with 4 entries and overflow=1, key_valid strobed in the same cycle: all outputs 0 next cycle; the first subsequent data read returns 8'h80.
